// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready on both sides.
// Ports: clk, rst (async, active-high), in_valid/in_ready, x, y,
//   ctrl={zx,nx,zy,ny,f,no}, out_valid/out_ready, out, zr, ng,
//   cy/ov (present only when ALU_OVF_EN is defined).
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef ALU_OVF_EN
  ,
  output logic             cy,
  output logic             ov
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_xb;
  logic [WIDTH-1:0] r_s1_yb;
  logic             r_s1_f;
  logic             r_s1_no;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_xfer;

  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_xb;
  logic [WIDTH-1:0] w_ya;
  logic [WIDTH-1:0] w_yb;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_res;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_in_xfer = in_valid && w_s1_adv;

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

  // Operand preconditioning happens before S1 so S2 only sees add/and.
  assign w_xa = ctrl[5] ? '0 : x;
  assign w_xb = ctrl[4] ? ~w_xa : w_xa;
  assign w_ya = ctrl[3] ? '0 : y;
  assign w_yb = ctrl[2] ? ~w_ya : w_ya;

`ifdef ALU_OVF_EN
  logic [WIDTH:0] w_sum_ext;
  logic           w_cy;
  logic           w_ov;
  logic           r_cy;
  logic           r_ov;

  assign w_sum_ext = {1'b0, r_s1_xb} + {1'b0, r_s1_yb};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  assign w_cy      = r_s1_f && w_sum_ext[WIDTH];
  assign w_ov      = r_s1_f
                  && (r_s1_xb[WIDTH-1] == r_s1_yb[WIDTH-1])
                  && (w_sum[WIDTH-1] != r_s1_xb[WIDTH-1]);
  assign cy        = r_cy;
  assign ov        = r_ov;
`else
  assign w_sum     = r_s1_xb + r_s1_yb;
`endif

  assign w_r   = r_s1_f ? w_sum : (r_s1_xb & r_s1_yb);
  assign w_res = r_s1_no ? ~w_r : w_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_xb    <= '0;
      r_s1_yb    <= '0;
      r_s1_f     <= 1'b0;
      r_s1_no    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_xfer) begin
        r_s1_xb <= w_xb;
        r_s1_yb <= w_yb;
        r_s1_f  <= ctrl[1];
        r_s1_no <= ctrl[0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zr       <= 1'b0;
      r_ng       <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_out <= w_res;
        r_zr  <= (w_res == '0);
        r_ng  <= w_res[WIDTH-1];
      end
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cy <= 1'b0;
      r_ov <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_cy <= w_cy;
      r_ov <= w_ov;
    end
  end
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe: directed + random checks of hack_alu_pipe
// against a queue-based behavioural model.
module tb_hack_alu_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] o;
    logic         zr;
    logic         ng;
    logic         cy;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [5:0]   ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         zr;
  logic         ng;

  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [7:0]   x8 = '0;
  logic [7:0]   y8 = '0;
  logic [5:0]   ctrl8 = '0;
  logic         out_valid8;
  logic         out_ready8 = 1'b1;
  logic [7:0]   out8;
  logic         zr8;
  logic         ng8;

`ifdef ALU_OVF_EN
  logic cy, ov, cy8, ov8;
`endif

  hack_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng)
`ifdef ALU_OVF_EN
    , .cy(cy), .ov(ov)
`endif
  );

  hack_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .ctrl(ctrl8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zr(zr8), .ng(ng8)
`ifdef ALU_OVF_EN
    , .cy(cy8), .ov(ov8)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Hack semantics with plain integer arithmetic.
  function automatic res_t model(logic [W-1:0] xi, logic [W-1:0] yi,
                                 logic [5:0] c);
    res_t         r;
    logic [W-1:0] xv, yv, rv;
    longint       u, sx, sy, s;
    xv = c[5] ? '0 : xi;
    if (c[4]) xv = ~xv;
    yv = c[3] ? '0 : yi;
    if (c[2]) yv = ~yv;
    r = '0;
    if (c[1]) begin
      u  = longint'(xv) + longint'(yv);
      rv = W'(u % (longint'(1) << W));
      sx = longint'($signed(xv));
      sy = longint'($signed(yv));
      s  = sx + sy;
      r.cy = (u >= (longint'(1) << W));
      r.ov = (s > 32767) || (s < -32768);
    end else begin
      rv = xv & yv;
    end
    if (c[0]) rv = ~rv;
    r.o  = rv;
    r.zr = (rv == 0);
    r.ng = rv[W-1];
    return r;
  endfunction

  res_t exp_q[$];
  int   age_q[$];

  // One compare process: every negedge, predict handshakes and data.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      logic eir, eov, pop, push;
      eir = (exp_q.size() < 2) || out_ready;
      eov = (exp_q.size() > 0) && (age_q[0] >= 1);
      chk("in_ready", in_ready, eir);
      chk("out_valid", out_valid, eov);
      if (eov && out_valid) begin
        chk("out", out, exp_q[0].o);
        chk("zr", zr, exp_q[0].zr);
        chk("ng", ng, exp_q[0].ng);
`ifdef ALU_OVF_EN
        chk("cy", cy, exp_q[0].cy);
        chk("ov", ov, exp_q[0].ov);
`endif
      end
      pop  = eov && out_ready;
      push = in_valid && eir;
      if (pop) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (push) begin
        exp_q.push_back(model(x, y, ctrl));
        age_q.push_back(0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic [W-1:0] a, logic [W-1:0] b, logic [5:0] c);
    in_valid = 1'b1;
    x = a;
    y = b;
    ctrl = c;
  endtask

  res_t m;

  initial begin
    // model pinning
    m = model(16'd5, 16'd7, 6'b010011);
    chk("model_xmy", m.o, 16'hFFFE);
    m = model(16'h7FFF, 16'h0001, 6'b000010);
    chk("model_ov", {m.o, m.cy, m.ov}, {16'h8000, 1'b0, 1'b1});
    m = model(16'hFFFF, 16'h0001, 6'b000010);
    chk("model_cy", {m.o, m.zr, m.cy, m.ov}, {16'h0000, 1'b1, 1'b1, 1'b0});

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", {out, zr, ng}, 0);
`ifdef ALU_OVF_EN
    chk("rst_cyov", {cy, ov}, 0);
`endif
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // x - y
    step();
    op(16'd5, 16'd7, 6'b010011);
    step();
    in_valid = 1'b0;
    step();
    chk("xmy_valid", out_valid, 1);
    chk("xmy", {out, zr, ng}, {16'hFFFE, 1'b0, 1'b1});

    // back-to-back
    op(16'h00F0, 16'h0FF0, 6'b000000);
    step();
    op(16'h00F0, 16'h0FF0, 6'b101010);
    step();
    chk("b2b_and", {out_valid, out, zr, ng}, {1'b1, 16'h00F0, 1'b0, 1'b0});
    op(16'h00F0, 16'h0FF0, 6'b111010);
    step();
    chk("b2b_zero", {out_valid, out, zr, ng}, {1'b1, 16'h0000, 1'b1, 1'b0});
    in_valid = 1'b0;
    step();
    chk("b2b_m1", {out_valid, out, zr, ng}, {1'b1, 16'hFFFF, 1'b0, 1'b1});
    step();

    // stall with three ops
    out_ready = 1'b0;
    op(16'd1, 16'd2, 6'b000010);
    step();
    op(16'd10, 16'd3, 6'b010011);
    step();
    op(16'h1234, 16'h00FF, 6'b000000);
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", {out_valid, out}, {1'b1, 16'd3});
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();

`ifdef ALU_OVF_EN
    op(16'h7FFF, 16'h0001, 6'b000010);
    step();
    op(16'hFFFF, 16'h0001, 6'b000010);
    step();
    chk("ovf1", {out, ng, cy, ov}, {16'h8000, 1'b1, 1'b0, 1'b1});
    in_valid = 1'b0;
    step();
    chk("ovf2", {out, zr, cy, ov}, {16'h0000, 1'b1, 1'b1, 1'b0});
    step();
`endif

    // width 8
    in_valid8 = 1'b1;
    x8 = 8'h80;
    y8 = 8'h80;
    ctrl8 = 6'b000010;
    step();
    in_valid8 = 1'b0;
    step();
    chk("w8", {out_valid8, out8, zr8}, {1'b1, 8'h00, 1'b1});
`ifdef ALU_OVF_EN
    chk("w8_cyov", {cy8, ov8}, {1'b1, 1'b1});
`endif

    // async reset with both stages full
    out_ready = 1'b0;
    op(16'd3, 16'd4, 6'b000010);
    step();
    op(16'd8, 16'd9, 6'b000010);
    step();
    in_valid = 1'b0;
    #2;
    chk("full_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_out", out, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rel2_in_ready", in_ready, 1);
    step();
    op(16'hAAAA, 16'h5555, 6'b000010);
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst", {out_valid, out}, {1'b1, 16'hFFFF});
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 7) == 0) x = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) y = 16'hFFFF;
      ctrl = 6'($urandom);
      out_ready = (i % 200 < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
